nes_joypad_reader: RTL and testbench

- Host-side reader for a standard NES controller, the 4021-style parallel-in/serial-out shift register.
- Periodically drives the controller's latch and clock lines, shifts in the 8 button bits, and presents them as a parallel byte with a one-cycle valid strobe.
- Sits in the nes top level between the board's controller pins and the $4016 input-port logic.
- Runs entirely on sys_clock.

---
 rtl/nes_joypad_reader.sv | 189 ++++++++++++++++++
 tb/tb_nes_joypad_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nes_joypad_reader.sv
// nes_joypad_reader
//   Host-side poller for a standard NES controller (4021-style parallel-in /
//   serial-out shift register). Every POLL_CYCLES sys_clock cycles it pulses
//   pad_latch, then clocks out the eight button bits on pad_clk. The bits are
//   presented as an active-high byte on buttons, with a one-cycle valid strobe.
//
// Parameters
//   LATCH_CYCLES : pad_latch high width in sys_clock cycles (>= 1)
//   HALF_PERIOD  : pad_clk high and low phase length in cycles (>= 3)
//   POLL_CYCLES  : cycles between poll starts (> LATCH_CYCLES + 15*HALF_PERIOD)
//
// Ports
//   sys_clock : system clock, rising edge
//   reset     : synchronous, active-high
//   enable    : 1 = polls may start; a poll already running always completes
//   pad_data  : serial data from the controller, active-low, asynchronous
//   pad_latch : latch strobe to the controller, active-high
//   pad_clk   : shift clock to the controller, idles low
//   buttons   : [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right,
//               1 = pressed
//   valid     : one-cycle pulse in the cycle buttons first shows a new value
//   busy      : 1 while a poll is in progress
//
// Build option
//   JOYPAD_DEBOUNCE_EN : when defined, a button bit only changes once two
//   consecutive polls agree on its new value.

module nes_joypad_reader #(
  parameter int LATCH_CYCLES = 12,
  parameter int HALF_PERIOD  = 6,
  parameter int POLL_CYCLES  = 16667
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);

  localparam int TIMER_W = $clog2(POLL_CYCLES);
  localparam int PH_MAX  = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
  localparam int PH_W    = $clog2(PH_MAX);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_CYCLES - 1);
  localparam logic [PH_W-1:0]    LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0]    HALF_LAST  = PH_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW0,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [PH_W-1:0]    ph, ph_nxt;
  logic [2:0]         bit_cnt;
  logic [TIMER_W-1:0] timer;
  logic               poll_start;
  logic               capture;
  logic [2:0]         capture_idx;
  logic               sync_p0, sync_p1;
  logic [7:0]         shift_raw;
  logic [7:0]         buttons_nxt;

`ifdef JOYPAD_DEBOUNCE_EN
  logic [7:0] prev_raw;

  // Bits on which the last two raw samples agree take the new value; the
  // rest hold what was previously reported.
  function automatic logic [7:0] debounce(input logic [7:0] cur,
                                          input logic [7:0] prev,
                                          input logic [7:0] held);
    logic [7:0] agree;
    agree = ~(cur ^ prev);
    return (cur & agree) | (held & ~agree);
  endfunction

  assign buttons_nxt = debounce(shift_raw, prev_raw, buttons);
`else
  assign buttons_nxt = shift_raw;
`endif

  assign poll_start  = enable && (timer == TIMER_LAST);
  assign capture_idx = (state == S_LOW0) ? 3'd0 : bit_cnt;

  always_comb begin
    state_nxt = state;
    ph_nxt    = ph + 1'b1;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        ph_nxt = '0;
        if (poll_start) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        if (ph == LATCH_LAST) begin
          state_nxt = S_LOW0;
          ph_nxt    = '0;
        end
      end
      S_LOW0: begin
        if (ph == HALF_LAST) begin
          capture   = 1'b1;
          state_nxt = S_HIGH;
          ph_nxt    = '0;
        end
      end
      S_HIGH: begin
        if (ph == HALF_LAST) begin
          state_nxt = S_LOW;
          ph_nxt    = '0;
        end
      end
      S_LOW: begin
        if (ph == HALF_LAST) begin
          capture   = 1'b1;
          state_nxt = (bit_cnt == 3'd7) ? S_DONE : S_HIGH;
          ph_nxt    = '0;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        ph_nxt    = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        ph_nxt    = '0;
      end
    endcase
  end

  // Control: state, counters, synchronizer and registered pad/status outputs.
  // Pad outputs are registered from the next state so they are glitch-free
  // and still track the state register cycle for cycle.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state     <= S_IDLE;
      ph        <= '0;
      bit_cnt   <= 3'd0;
      timer     <= '0;
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      buttons   <= 8'h00;
`ifdef JOYPAD_DEBOUNCE_EN
      prev_raw  <= 8'h00;
`endif
    end else begin
      state     <= state_nxt;
      ph        <= ph_nxt;
      sync_p0   <= pad_data;
      sync_p1   <= sync_p0;
      pad_latch <= (state_nxt == S_LATCH);
      pad_clk   <= (state_nxt == S_HIGH);
      busy      <= (state_nxt != S_IDLE);
      valid     <= (state == S_DONE);

      if (!enable)                 timer <= '0;
      else if (timer == TIMER_LAST) timer <= '0;
      else                         timer <= timer + 1'b1;

      if (capture) bit_cnt <= capture_idx + 3'd1;

      if (state == S_DONE) begin
        buttons  <= buttons_nxt;
`ifdef JOYPAD_DEBOUNCE_EN
        prev_raw <= shift_raw;
`endif
      end
    end
  end

  // Sample stage: synchronized pad data lands in the raw shift byte at the
  // end of each low phase, inverted to active-high.
  always_ff @(posedge sys_clock) begin
    if (capture) shift_raw[capture_idx] <= ~sync_p1;
  end

endmodule

// File: tb/tb_nes_joypad_reader.sv
module tb_nes_joypad_reader;

  localparam int LATCH = 12;
  localparam int HALF  = 6;
  localparam int POLL  = 2000;

  logic       sys_clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  nes_joypad_reader #(
    .LATCH_CYCLES(LATCH),
    .HALF_PERIOD (HALF),
    .POLL_CYCLES (POLL)
  ) dut (
    .sys_clock(sys_clock),
    .reset    (reset),
    .enable   (enable),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .buttons  (buttons),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 sys_clock = ~sys_clock;

  int cyc = 0;
  always @(posedge sys_clock) cyc++;

  // Controller model: 4021 loads on latch, first bit (A) out immediately,
  // next bit on each pad_clk rising edge, ones after the eighth bit.
  logic [7:0] pad_word = 8'hFF;
  int         idx = 8;
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch === 1'b1) idx = 0;
    else if (idx < 8)       idx = idx + 1;
  end
  assign pad_data = (idx < 8) ? pad_word[idx] : 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Waits (bounded) for a poll, then records its waveform until valid.
  task automatic measure_poll(input bit drop_en, output int wait_k, output int latch_w,
                              output int n_rise, output int min_hi, output int max_hi,
                              output int t_valid, output int valid_cyc, output bit to);
    int hi_run;
    bit prev_clk;
    to = 0; latch_w = 0; n_rise = 0; min_hi = 1000; max_hi = 0;
    t_valid = -1; valid_cyc = 0; hi_run = 0; prev_clk = 0; wait_k = 0;
    while (pad_latch !== 1'b1 && wait_k < POLL + 200) begin
      @(negedge sys_clock);
      wait_k++;
    end
    if (pad_latch !== 1'b1) begin
      to = 1;
      return;
    end
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pad_latch === 1'b1) latch_w++;
      if (pad_clk === 1'b1) begin
        if (!prev_clk) n_rise++;
        hi_run++;
      end else if (prev_clk) begin
        if (hi_run < min_hi) min_hi = hi_run;
        if (hi_run > max_hi) max_hi = hi_run;
        hi_run = 0;
      end
      prev_clk = (pad_clk === 1'b1);
      if (valid === 1'b1) begin
        t_valid   = i;
        valid_cyc = cyc;
        break;
      end
      @(negedge sys_clock);
    end
    if (t_valid < 0) to = 1;
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[3];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wait_k, latch_w, n_rise, min_hi, max_hi, t_valid, valid_cyc, last_valid;
    int bad, cnt;
    bit to;
    logic [7:0] exp_drop;

`ifdef JOYPAD_DEBOUNCE_EN
    tbl[0] = '{word: 8'hFE, exp: 8'h00};
    tbl[1] = '{word: 8'hFE, exp: 8'h01};
    tbl[2] = '{word: 8'hFF, exp: 8'h01};
    exp_drop = 8'h00;
`else
    tbl[0] = '{word: 8'hFF, exp: 8'h00};
    tbl[1] = '{word: 8'hFF, exp: 8'h00};
    tbl[2] = '{word: 8'hFA, exp: 8'h05};
    exp_drop = 8'h80;
`endif

    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge sys_clock);
    check("rst_latch",   pad_latch, 0);
    check("rst_clk",     pad_clk,   0);
    check("rst_buttons", buttons,   0);
    check("rst_valid",   valid,     0);
    check("rst_busy",    busy,      0);
    reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge sys_clock);
      if (pad_latch !== 1'b0 || pad_clk !== 1'b0 || valid !== 1'b0 ||
          busy !== 1'b0 || buttons !== 8'h00) bad++;
    end
    check("idle_quiet", bad, 0);

    // Table-driven polls with enable held high.
    enable = 1'b1;
    last_valid = 0;
    for (int v = 0; v < 3; v++) begin
      pad_word = tbl[v].word;
      measure_poll(1'b0, wait_k, latch_w, n_rise, min_hi, max_hi, t_valid, valid_cyc, to);
      if (to) begin
        check("poll_timeout", 1, 0);
      end else begin
        if (v == 0) check("first_poll_delay", wait_k, POLL);
        check("latch_width", latch_w, LATCH);
        check("clk_rises",   n_rise,  7);
        check("clk_hi_min",  min_hi,  HALF);
        check("clk_hi_max",  max_hi,  HALF);
        check("valid_delay", t_valid, LATCH + 15 * HALF + 1);
        check("buttons",     buttons, tbl[v].exp);
        if (v > 0) check("poll_spacing", valid_cyc - last_valid, POLL);
        last_valid = valid_cyc;
        @(negedge sys_clock);
        check("valid_one_cycle", valid, 0);
        check("busy_after",      busy,  0);
      end
    end

    // Reset during the 4th pad_clk high phase aborts the poll.
    pad_word = 8'h00;
    cnt = 0;
    while (pad_latch !== 1'b1 && cnt < POLL + 200) begin
      @(negedge sys_clock);
      cnt++;
    end
    check("abort_poll_seen", pad_latch, 1);
    n_rise = 0;
    cnt = 0;
    begin
      bit prev_clk;
      prev_clk = 0;
      while (n_rise < 4 && cnt < 200) begin
        @(negedge sys_clock);
        cnt++;
        if (pad_clk === 1'b1 && !prev_clk) n_rise++;
        prev_clk = (pad_clk === 1'b1);
      end
    end
    check("abort_reach_high4", n_rise, 4);
    @(negedge sys_clock);
    check("abort_in_high", pad_clk, 1);
    reset = 1'b1;
    @(negedge sys_clock);
    check("abort_clk",     pad_clk,   0);
    check("abort_latch",   pad_latch, 0);
    check("abort_busy",    busy,      0);
    check("abort_buttons", buttons,   0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clock);
      if (valid === 1'b1) cnt++;
    end
    check("abort_no_valid", cnt, 0);
    check("abort_buttons_hold", buttons, 0);

    // Enable dropped during LATCH: poll still completes, no further polls.
    pad_word = 8'h7F;
    measure_poll(1'b1, wait_k, latch_w, n_rise, min_hi, max_hi, t_valid, valid_cyc, to);
    if (to) begin
      check("drop_timeout", 1, 0);
    end else begin
      check("drop_latch_width", latch_w, LATCH);
      check("drop_clk_rises",   n_rise,  7);
      check("drop_valid_delay", t_valid, LATCH + 15 * HALF + 1);
      check("drop_buttons",     buttons, exp_drop);
    end
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 3 * POLL; i++) begin
      @(negedge sys_clock);
      if (valid === 1'b1) cnt++;
      if (pad_latch !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("drop_no_more_valid", cnt, 0);
    check("drop_no_more_polls", bad, 0);
    check("drop_buttons_hold",  buttons, exp_drop);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
